ex_divider: RTL

EX_DIVIDER -- requirements
Module: ex_divider

---
 rtl/ex_divider.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_divider.sv
// Multi-cycle DIV/DIVU unit for the EX stage: restoring radix-2 division,
// 32 cycles for a nonzero divisor, 2 cycles to flag a zero divisor.
module ex_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        stallreq_for_ex,
  output logic        result_valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned RW = 2 * W + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   work, work_step;
  logic [W:0]      trial;
  logic [W-1:0]    a_mag, b_mag, a_mag_c, b_mag_c;
  logic [W-1:0]    q_raw, r_raw, q_fix, r_fix;
  logic            sign_a, sign_b, signed_op;
  logic            start, finish_div, finish_zero;

  // Operand magnitudes as captured on leaving IDLE
  assign a_mag_c = (div_signed && dividend[W-1]) ? W'(-dividend) : dividend;
  assign b_mag_c = (div_signed && divisor[W-1])  ? W'(-divisor)  : divisor;

  // work[64:32] is the shifted partial remainder; low bits collect quotient bits
  assign trial     = work[RW-1:W] - {1'b0, b_mag};
  assign work_step = trial[W] ? {work[RW-2:0], 1'b0}
                              : {trial[W-1:0], work[W-1:0], 1'b1};
  assign q_raw     = work_step[W-1:0];
  assign r_raw     = work_step[RW-1:W+1];
  assign q_fix     = (signed_op && (sign_a ^ sign_b)) ? W'(-q_raw) : q_raw;
  assign r_fix     = (signed_op && sign_a) ? W'(-r_raw) : r_raw;

  assign stallreq_for_ex = ~rst & div_start & ~annul & (state != END);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    start       = 1'b0;
    finish_div  = 1'b0;
    finish_zero = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          start     = 1'b1;
          state_nxt = (divisor == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        finish_zero = 1'b1;
        state_nxt   = END;
      end
      ON: begin
        if (cnt == CW'(W - 1)) begin
          finish_div = 1'b1;
          state_nxt  = END;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything, including a start in IDLE
    if (annul) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      start       = 1'b0;
      finish_div  = 1'b0;
      finish_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work         <= '0;
      a_mag        <= '0;
      b_mag        <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      signed_op    <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      if (start) begin
        signed_op <= div_signed;
        sign_a    <= dividend[W-1];
        sign_b    <= divisor[W-1];
        a_mag     <= a_mag_c;
        b_mag     <= b_mag_c;
        work      <= {W'(0), a_mag_c, 1'b0};
      end else if (state == ON) begin
        work <= work_step;
      end
      if (finish_div) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end else if (finish_zero) begin
        quotient  <= '0;
        remainder <= '0;
      end
      result_valid <= finish_div | finish_zero;
      div_by_zero  <= finish_zero;
    end
  end

endmodule
